// File: rtl/chip8_keypad_pkg.sv
// chip8_keypad_pkg: shared types, constants and the matrix key map for the
// CHIP-8 hex keypad scanner.
package chip8_keypad_pkg;

    // Key identifier: 0..15 is a real key, 16 means "no key"
    typedef logic [4:0] key_id_t;

    localparam key_id_t KEY_NONE = 5'd16;

    // Physical matrix position to CHIP-8 key code
    //   row 0: 1 2 3 C
    //   row 1: 4 5 6 D
    //   row 2: 7 8 9 E
    //   row 3: A 0 B F
    function automatic logic [3:0] key_at(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] key;
        key = 4'h0;
        case ({row, col})
            4'b00_00: key = 4'h1;
            4'b00_01: key = 4'h2;
            4'b00_10: key = 4'h3;
            4'b00_11: key = 4'hC;
            4'b01_00: key = 4'h4;
            4'b01_01: key = 4'h5;
            4'b01_10: key = 4'h6;
            4'b01_11: key = 4'hD;
            4'b10_00: key = 4'h7;
            4'b10_01: key = 4'h8;
            4'b10_10: key = 4'h9;
            4'b10_11: key = 4'hE;
            4'b11_00: key = 4'hA;
            4'b11_01: key = 4'h0;
            4'b11_10: key = 4'hB;
            default:  key = 4'hF;
        endcase
        return key;
    endfunction

endpackage

// File: rtl/keypad_debouncer.sv
// keypad_debouncer: debounce state for a single matrix key. The counter and
// stable bit only move on this key's sample cycle; rise/fall pulse in the
// same cycle as the deciding sample so the owner can register the event on
// the same edge that flips the stable bit.
module keypad_debouncer
    import chip8_keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;
    logic             flip;

    // Next-state: reset the run on agreement, count disagreement, flip on the Nth
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        flip     = sample_en && (raw != stable_q) && (cnt_q == CNT_W'(DEBOUNCE_SCANS - 1));
        if (sample_en) begin
            if (raw == stable_q) begin
                cnt_d = '0;
            end else if (flip) begin
                cnt_d    = '0;
                stable_d = raw;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;
    assign rise   = flip & raw;
    assign fall   = flip & ~raw;

endmodule

// File: rtl/chip8_keypad_scanner.sv
// chip8_keypad_scanner: scans the 4x4 hex keypad, debounces every key and
// drives the CHIP-8 core's input_keys bitmap and newest_key_down handshake.
// Build option: define KEYPAD_RELEASE_EVENT_EN to report releases instead of
// presses on newest_key_down (COSMAC VIP style Fx0A).
module chip8_keypad_scanner
    import chip8_keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [3:0]  col_drive,
    input  logic [3:0]  row_sense,
    input  logic        clear_newest_key_down,
    output logic [15:0] input_keys,
    output logic [4:0]  newest_key_down
);

    localparam int DIV_W = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);

    logic [3:0]       rowMeta_q;
    logic [3:0]       rowSync_q;
    logic             clrMeta_q;
    logic             clrSync_q;
    logic             clrPrev_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       col_q;
    logic [3:0]       colDrive_q;
    key_id_t          newest_q;
    key_id_t          newest_d;

    logic             sampleTick;
    logic             clrEdge;
    logic [15:0]      stableVec;
    logic [15:0]      riseVec;
    logic [15:0]      fallVec;
    logic [15:0]      keyEvent;
    logic             unusedEdges;

    assign sampleTick = (div_q == DIV_W'(SCAN_DIV - 1));
    assign clrEdge    = clrSync_q & ~clrPrev_q;

    // Two-flop synchronisers for the rows and the clear level, plus clear edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rowMeta_q <= 4'b1111;
            rowSync_q <= 4'b1111;
            clrMeta_q <= 1'b0;
            clrSync_q <= 1'b0;
            clrPrev_q <= 1'b0;
        end else begin
            rowMeta_q <= row_sense;
            rowSync_q <= rowMeta_q;
            clrMeta_q <= clear_newest_key_down;
            clrSync_q <= clrMeta_q;
            clrPrev_q <= clrSync_q;
        end
    end

    // Scan divider and column rotation; column drive is kept as its own register so the pins never glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= '0;
            col_q      <= 2'd0;
            colDrive_q <= 4'b1110;
        end else if (sampleTick) begin
            div_q      <= '0;
            col_q      <= col_q + 2'd1;
            colDrive_q <= {colDrive_q[2:0], colDrive_q[3]};
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // One debouncer per matrix node, stored at the key code's bit position
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            localparam logic [3:0] KEY = key_at(2'(r), 2'(c));
            keypad_debouncer #(
                .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
            ) u_debouncer (
                .clk       (clk),
                .rst_n     (rst_n),
                .sample_en (sampleTick && (col_q == 2'(c))),
                .raw       (~rowSync_q[r]),
                .stable    (stableVec[KEY]),
                .rise      (riseVec[KEY]),
                .fall      (fallVec[KEY])
            );
        end
    end

`ifdef KEYPAD_RELEASE_EVENT_EN
    assign keyEvent    = fallVec;
    assign unusedEdges = ^riseVec;
`else
    assign keyEvent    = riseVec;
    assign unusedEdges = ^fallVec;
`endif

    // Pick the reported key: only the sampled column can change, lowest row wins, a key event beats a clear edge
    always_comb begin
        logic [3:0] keyIdx;
        newest_d = newest_q;
        keyIdx   = 4'h0;
        for (int r = 3; r >= 0; r--) begin
            keyIdx = key_at(2'(r), col_q);
            if (keyEvent[keyIdx]) begin
                newest_d = {1'b0, keyIdx};
            end
        end
        if ((newest_d == newest_q) && !(|keyEvent) && clrEdge) begin
            newest_d = KEY_NONE;
        end
    end

    // Newest-key register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            newest_q <= KEY_NONE;
        end else begin
            newest_q <= newest_d;
        end
    end

    assign col_drive       = colDrive_q;
    assign input_keys      = stableVec;
    assign newest_key_down = newest_q;

endmodule

// File: tb/tb_chip8_keypad_scanner.sv
// tb_chip8_keypad_scanner: directed and randomized bench for the keypad
// scanner with a cycle-level behavioural model of the scan/debounce rules.
// Honours KEYPAD_RELEASE_EVENT_EN the same way as the design.
module tb_chip8_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 3;

`ifdef KEYPAD_RELEASE_EVENT_EN
    localparam logic EVENT_LEVEL = 1'b0;
`else
    localparam logic EVENT_LEVEL = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col_drive;
    logic [3:0]  row_sense;
    logic        clearNewest = 1'b0;
    logic [15:0] input_keys;
    logic [4:0]  newest_key_down;
    logic [15:0] pressed = '0;

    int checks = 0;
    int failures = 0;

    int keyMap [4][4] = '{'{1, 2, 3, 12}, '{4, 5, 6, 13}, '{7, 8, 9, 14}, '{10, 0, 11, 15}};

    // Behavioural model state
    int          t;
    logic [15:0] mStable;
    int          mCnt [16];
    logic [4:0]  mNewest;
    logic [15:0] pH0, pH1, pH2;
    logic        c0, c1, c2, c3;

    chip8_keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .col_drive             (col_drive),
        .row_sense             (row_sense),
        .clear_newest_key_down (clearNewest),
        .input_keys            (input_keys),
        .newest_key_down       (newest_key_down)
    );

    always #5 clk = ~clk;

    // Switch matrix: a row reads low when a pressed key sits on the driven column
    always_comb begin
        row_sense = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (col_drive[c] == 1'b0 && pressed[keyMap[r][c]]) begin
                    row_sense[r] = 1'b0;
                end
            end
        end
    end

    function automatic void modelReset();
        t       = 0;
        mStable = '0;
        mNewest = 5'd16;
        pH0 = '0; pH1 = '0; pH2 = '0;
        c0 = 1'b0; c1 = 1'b0; c2 = 1'b0; c3 = 1'b0;
        for (int k = 0; k < 16; k++) mCnt[k] = 0;
    endfunction

    function automatic logic [3:0] expColDrive();
        return ~(4'b0001 << ((t / SD) % 4));
    endfunction

    // Advance the model by one clock edge using the inputs presented in cycle t
    function automatic void modelStep();
        int col;
        int k;
        int ev;
        logic raw;
        pH2 = pH1; pH1 = pH0; pH0 = pressed;
        c3 = c2; c2 = c1; c1 = c0; c0 = clearNewest;
        col = (t / SD) % 4;
        ev  = -1;
        if ((t % SD) == SD - 1) begin
            for (int r = 3; r >= 0; r--) begin
                k   = keyMap[r][col];
                raw = pH2[k];
                if (raw == mStable[k]) begin
                    mCnt[k] = 0;
                end else begin
                    mCnt[k]++;
                    if (mCnt[k] == DB) begin
                        mStable[k] = raw;
                        mCnt[k]    = 0;
                        if (raw == EVENT_LEVEL) ev = k;
                    end
                end
            end
        end
        if (ev >= 0) mNewest = 5'(ev);
        else if (c2 && !c3) mNewest = 5'd16;
        t++;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            modelStep();
            @(negedge clk);
        end
    endtask

    task automatic runUntilKeys(input logic [15:0] want, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step(1);
            if (input_keys === want) ok = 1'b1;
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic test_reset();
        logic [3:0] colSeq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        pressed = '0;
        clearNewest = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({col_drive, input_keys, newest_key_down} !== {4'b1110, 16'h0000, 5'd16}) begin
            failures++;
            $display("[TB] FAIL reset_values got col=%b keys=%h newest=%0d want col=1110 keys=0000 newest=16",
                     col_drive, input_keys, newest_key_down);
        end
        rst_n = 1'b1;
        modelReset();
        for (int i = 1; i <= 20; i++) begin
            step(1);
            checks++;
            if ({col_drive, input_keys, newest_key_down} !== {expColDrive(), mStable, mNewest}) begin
                failures++;
                $display("[TB] FAIL reset_model t=%0d got col=%b keys=%h newest=%0d want col=%b keys=%h newest=%0d",
                         t, col_drive, input_keys, newest_key_down, expColDrive(), mStable, mNewest);
            end
            if (i % 4 == 0 && i <= 16) begin
                checks++;
                if (col_drive !== colSeq[i / 4]) begin
                    failures++;
                    $display("[TB] FAIL col_step after %0d cycles got %b want %b", i, col_drive, colSeq[i / 4]);
                end
            end
        end
    endtask

    task automatic test_press_key5();
        bit ok;
`ifdef KEYPAD_RELEASE_EVENT_EN
        logic [4:0] newestAfterPress = 5'd16;
`else
        logic [4:0] newestAfterPress = 5'd5;
`endif
        pressed = 16'h0020;
        runUntilKeys(16'h0020, 51, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL press5_latency got keys=%h want 0020 within 51 cycles", input_keys);
        end
        checks++;
        if (newest_key_down !== newestAfterPress || mNewest !== newestAfterPress) begin
            failures++;
            $display("[TB] FAIL press5_newest got %0d (model %0d) want %0d", newest_key_down, mNewest, newestAfterPress);
        end
        pressed = '0;
        runUntilKeys(16'h0000, 51, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL release5_latency got keys=%h want 0000 within 51 cycles", input_keys);
        end
        checks++;
        if (newest_key_down !== 5'd5) begin
            failures++;
            $display("[TB] FAIL release5_newest got %0d want 5", newest_key_down);
        end
    endtask

    task automatic test_bounce();
        logic [15:0] keysBefore;
        logic [4:0]  newestBefore;
        keysBefore   = input_keys;
        newestBefore = newest_key_down;
        for (int i = 0; i < 16 && (t % 16) != 8; i++) step(1);
        pressed = 16'h0020;
        for (int i = 0; i < 80; i++) begin
            if (i == 32) pressed = '0;
            step(1);
            checks++;
            if ({col_drive, input_keys, newest_key_down} !== {expColDrive(), keysBefore, newestBefore} ||
                {input_keys, newest_key_down} !== {mStable, mNewest}) begin
                failures++;
                $display("[TB] FAIL bounce t=%0d got keys=%h newest=%0d want keys=%h newest=%0d (model %h/%0d)",
                         t, input_keys, newest_key_down, keysBefore, newestBefore, mStable, mNewest);
            end
        end
    endtask

    task automatic test_clear();
        bit ok;
        clearNewest = 1'b1;
        step(2);
        checks++;
        if (newest_key_down !== 5'd5) begin
            failures++;
            $display("[TB] FAIL clear_early got %0d want 5 two cycles after clear", newest_key_down);
        end
        step(1);
        checks++;
        if ({input_keys, newest_key_down} !== {16'h0000, 5'd16}) begin
            failures++;
            $display("[TB] FAIL clear_latency got keys=%h newest=%0d want keys=0000 newest=16",
                     input_keys, newest_key_down);
        end
        pressed = 16'h0400;
        runUntilKeys(16'h0400, 51, ok);
        checks++;
        if (!ok || {input_keys, newest_key_down} !== {mStable, mNewest}) begin
            failures++;
            $display("[TB] FAIL clear_held_pressA got keys=%h newest=%0d want keys=0400 newest=%0d",
                     input_keys, newest_key_down, mNewest);
        end
        pressed = '0;
        runUntilKeys(16'h0000, 51, ok);
        checks++;
        if (!ok || newest_key_down !== 5'd10) begin
            failures++;
            $display("[TB] FAIL clear_held_keyA got keys=%h newest=%0d want keys=0000 newest=10",
                     input_keys, newest_key_down);
        end
        clearNewest = 1'b0;
        step(4);
    endtask

    task automatic test_simultaneous();
        bit ok;
`ifdef KEYPAD_RELEASE_EVENT_EN
        logic [4:0] newestAfterPress = 5'd10;
`else
        logic [4:0] newestAfterPress = 5'd1;
`endif
        pressed = 16'h0082;
        runUntilKeys(16'h0082, 51, ok);
        checks++;
        if (!ok || newest_key_down !== newestAfterPress) begin
            failures++;
            $display("[TB] FAIL simultaneous got keys=%h newest=%0d want keys=0082 newest=%0d",
                     input_keys, newest_key_down, newestAfterPress);
        end
        pressed = 16'h0086;
        step(20);
        checks++;
        if ({input_keys, newest_key_down} !== {mStable, mNewest}) begin
            failures++;
            $display("[TB] FAIL mid_debounce got keys=%h newest=%0d want keys=%h newest=%0d",
                     input_keys, newest_key_down, mStable, mNewest);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({col_drive, input_keys, newest_key_down} !== {4'b1110, 16'h0000, 5'd16}) begin
            failures++;
            $display("[TB] FAIL async_reset got col=%b keys=%h newest=%0d want col=1110 keys=0000 newest=16",
                     col_drive, input_keys, newest_key_down);
        end
        @(negedge clk);
        @(negedge clk);
        pressed = '0;
        rst_n = 1'b1;
        modelReset();
        step(8);
    endtask

    task automatic test_event_polarity();
        bit ok;
`ifdef KEYPAD_RELEASE_EVENT_EN
        logic [4:0] newestAfterPress = 5'd16;
`else
        logic [4:0] newestAfterPress = 5'd15;
`endif
        pressed = 16'h8000;
        runUntilKeys(16'h8000, 51, ok);
        checks++;
        if (!ok || newest_key_down !== newestAfterPress) begin
            failures++;
            $display("[TB] FAIL pressF got keys=%h newest=%0d want keys=8000 newest=%0d",
                     input_keys, newest_key_down, newestAfterPress);
        end
        pressed = '0;
        runUntilKeys(16'h0000, 51, ok);
        checks++;
        if (!ok || newest_key_down !== 5'd15) begin
            failures++;
            $display("[TB] FAIL releaseF got keys=%h newest=%0d want keys=0000 newest=15",
                     input_keys, newest_key_down);
        end
    endtask

    task automatic test_random();
        int hold;
        for (int seg = 0; seg < 60; seg++) begin
            case ($urandom_range(0, 3))
                0:       pressed = '0;
                1:       pressed = 16'(1) << $urandom_range(0, 15);
                2:       pressed = 16'($urandom) & 16'($urandom);
                default: pressed = pressed ^ (16'(1) << $urandom_range(0, 15));
            endcase
            if ($urandom_range(0, 3) == 0) clearNewest = ~clearNewest;
            if ($urandom_range(0, 19) == 0) applyReset();
            hold = $urandom_range(1, 70);
            for (int i = 0; i < hold; i++) begin
                step(1);
                checks++;
                if ({col_drive, input_keys, newest_key_down} !== {expColDrive(), mStable, mNewest}) begin
                    failures++;
                    $display("[TB] FAIL random t=%0d got col=%b keys=%h newest=%0d want col=%b keys=%h newest=%0d",
                             t, col_drive, input_keys, newest_key_down, expColDrive(), mStable, mNewest);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_press_key5();
        test_bounce();
        test_clear();
        test_simultaneous();
        test_event_polarity();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
